// File: rtl/regfile_write_arbiter_if.sv
// Bundles the two writeback request channels and the register-file write port
// so the arbiter and its requesters share one connection.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic [4:0]        req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [4:0]        req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [4:0]        A3;
  logic [DATA_W-1:0] WD3;
  logic              WE3;

  // Requester side: drives the write requests and watches grants and the write port.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  A3, WD3, WE3
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output A3, WD3, WE3
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with a one-cycle registered write port.
// Define RR_ARB_EN for round-robin contention resolution; default is fixed priority (req0 wins).
module regfile_write_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic                           hold,
  regfile_write_arbiter_if.slave         bus,
  output logic                           last_grant
);

  logic              grant0;
  logic              grant1;
  logic [4:0]        a3_q,  a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              we3_q, we3_d;
  logic              last_grant_q, last_grant_d;

  // Grants are purely combinational so a requester learns of acceptance in the same cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !hold) begin
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef RR_ARB_EN
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
`else
        grant0 = 1'b1;
`endif
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    a3_d         = a3_q;
    wd3_d        = wd3_q;
    we3_d        = 1'b0;
    last_grant_d = last_grant_q;
    // Writes to x0 are accepted but suppressed at the enable.
    if (grant0) begin
      a3_d         = bus.req0_addr;
      wd3_d        = bus.req0_data;
      we3_d        = |bus.req0_addr;
      last_grant_d = 1'b0;
    end else if (grant1) begin
      a3_d         = bus.req1_addr;
      wd3_d        = bus.req1_data;
      we3_d        = |bus.req1_addr;
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      a3_q         <= 5'd0;
      wd3_q        <= '0;
      we3_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      we3_q        <= we3_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.A3         = a3_q;
  assign bus.WD3        = wd3_q;
  assign bus.WE3        = we3_q;
  assign last_grant     = last_grant_q;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, write-data width; all data ports SHALL use DATA_W.
REQ-002 CLK  input  1  single clock; all state SHALL update on posedge CLK.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 hold  input  1  when high, no new grant is issued.
REQ-005 req0_valid, req1_valid  input  1 each  requester 0 (ALU writeback) / requester 1 (load writeback) has a write.
REQ-006 req0_addr, req1_addr  input  5 each  destination register index.
REQ-007 req0_data, req1_data  input  DATA_W each  write data.
REQ-008 req0_ready, req1_ready  output  1 each  grant; transfer occurs when valid and ready are high in the same cycle.
REQ-009 A3  output  5  register-file write address.
REQ-010 WD3  output  DATA_W  register-file write data.
REQ-011 WE3  output  1  register-file write enable.
REQ-012 last_grant  output  1  index of the most recently granted requester.

Function
REQ-013 ready outputs SHALL be combinational from the valids, hold, rst and last_grant; at most one ready SHALL be high per cycle.
REQ-014 A ready SHALL be high only while its own valid is high, hold is low and rst is low.
REQ-015 Only one valid high: that requester SHALL be granted.
REQ-016 Both valid high: the winner SHALL be chosen per REQ-027/REQ-028; the loser's ready SHALL stay low, and the loser SHALL keep valid, addr and data stable until it is granted.
REQ-017 Output stage is a single register: a grant in cycle N SHALL drive A3/WD3 with the granted addr/data and WE3=1 in cycle N+1 (1-cycle latency).
REQ-018 A granted write with addr 0 SHALL be accepted (ready high) but SHALL produce WE3=0 in cycle N+1; x0 is never written.
REQ-019 Any cycle with no grant SHALL produce WE3=0 in the next cycle; A3/WD3 SHALL hold their previous values.
REQ-020 last_grant SHALL update only on a grant.
REQ-021 Both requesters targeting the same nonzero addr SHALL produce two back-to-back writes in grant order; the later grant's data is final.
REQ-022 hold rising while a write is in the output register SHALL NOT cancel that write; it still issues in the next cycle.
REQ-023 Throughput SHALL be one write per cycle with no bubbles while any requester is valid and hold is low.

Reset
REQ-024 On rst asserted, asynchronously: WE3=0, A3=0, WD3=0, last_grant=1, both readies 0.
REQ-025 Reset asserted mid-operation SHALL discard the pending output-register write; WE3 SHALL be 0 in the cycle rst rises.
REQ-026 The first cycle after rst falls SHALL be able to grant.

Configuration
REQ-027 With macro RR_ARB_EN defined: on contention, the requester not equal to last_grant SHALL win (round-robin, alternating under continuous contention).
REQ-028 With RR_ARB_EN undefined: on contention, requester 0 SHALL always win (fixed priority); last_grant is still maintained.

Verification
REQ-029 req0 valid, addr 5, data 0xDEADBEEF, req1 idle -> req0_ready=1 in cycle N; cycle N+1: WE3=1, A3=5, WD3=0xDEADBEEF.
REQ-030 Both valid (addr 3/0x11, addr 4/0x22) for 4 cycles after reset, RR_ARB_EN defined -> grants 0,1,0,1; writes (3,0x11),(4,0x22),(3,0x11),(4,0x22). RR_ARB_EN undefined -> grants 0,0,0,0.
REQ-031 req1 valid addr 0 data 0x1234 -> req1_ready=1; next cycle WE3=0.
REQ-032 Both valid, addr 7, data 0xAAAA (req0) and 0xBBBB (req1), RR_ARB_EN defined -> WE3=1 in two consecutive cycles, A3=7, WD3 0xAAAA then 0xBBBB.
REQ-033 Grant in cycle N, hold=1 from cycle N+1 -> write issues in cycle N+1, readies 0 while hold=1, WE3=0 afterwards until hold=0.
REQ-034 rst asserted between posedges while the output register holds a valid write -> WE3, A3, WD3 go to 0 immediately, last_grant=1, no write issued.
